// File: rtl/iic_eeprom_slave.sv
// I2C target emulating a 24-series EEPROM (16-bit word address, page-wrapped writes, sequential reads).
// SDA changes within 3 i_clk of the SCL fall; `IIC_SLAVE_WP_EN` adds the i_wp write-protect input.
module iic_eeprom_slave #(
    parameter logic [3:0] P_DEV_HI  = 4'b1010,
    parameter int         P_MEM_AW  = 8,
    parameter int         P_PAGE_AW = 5
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [2:0]          i_dev_addr,
`ifdef IIC_SLAVE_WP_EN
    input  logic                i_wp,
`endif
    input  logic                i_iic_scl,
    inout  wire                 io_iic_sda,
    output logic                o_busy,
    output logic                o_wr_valid,
    output logic [P_MEM_AW-1:0] o_wr_addr,
    output logic [7:0]          o_wr_data
);

    typedef enum logic [3:0] {
        IDLE, DEV, ACK_DEV, AH, ACK_AH, AL, ACK_AL, WR, ACK_WR, RD, RD_ACK
    } state_t;

    logic [1:0] scl_sync, sda_sync;
    logic       scl_q, sda_q;
    logic       scl, sda, scl_rise, scl_fall, start_c, stop_c;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], i_iic_scl};
            sda_sync <= {sda_sync[0], io_iic_sda};
            scl_q    <= scl_sync[1];
            sda_q    <= sda_sync[1];
        end
    end

    assign scl      = scl_sync[1];
    assign sda      = sda_sync[1];
    assign scl_rise = scl & ~scl_q;
    assign scl_fall = ~scl & scl_q;
    assign start_c  = scl & scl_q & sda_q & ~sda;
    assign stop_c   = scl & scl_q & ~sda_q & sda;

    state_t              state;
    logic [3:0]          bit_cnt;
    logic [7:0]          shreg, addr_hi, tx;
    logic [P_MEM_AW-1:0] ptr;
    logic                sda_oe;
    logic [7:0]          mem [2**P_MEM_AW];

    logic                 rx_state, byte_done, dev_match, wr_en;
    logic [7:0]           rd_byte;
    logic [15:0]          addr_full;
    logic [P_PAGE_AW-1:0] page_off;
    logic [P_MEM_AW-1:0]  ptr_page_inc;
    logic                 unused_addr;

    assign rx_state     = state inside {DEV, AH, AL, WR};
    assign byte_done    = scl_fall && (bit_cnt == 4'd8);
    assign dev_match    = (shreg[7:1] == {P_DEV_HI, i_dev_addr});
    assign rd_byte      = mem[ptr];
    assign addr_full    = {addr_hi, shreg};
    assign unused_addr  = ^addr_full;
    // Writes stay inside the current page: only the offset bits advance.
    assign page_off     = ptr[P_PAGE_AW-1:0] + P_PAGE_AW'(1);
    assign ptr_page_inc = {ptr[P_MEM_AW-1:P_PAGE_AW], page_off};
`ifdef IIC_SLAVE_WP_EN
    assign wr_en = ~i_wp;
`else
    assign wr_en = 1'b1;
`endif

    assign io_iic_sda = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            addr_hi    <= '0;
            tx         <= '0;
            ptr        <= '0;
            sda_oe     <= 1'b0;
            o_busy     <= 1'b0;
            o_wr_valid <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
        end else begin
            o_wr_valid <= 1'b0;
            if (start_c) begin
                state   <= DEV;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else if (stop_c) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                o_busy <= 1'b0;
            end else begin
                if (scl_rise && (rx_state || state == RD)) begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
                if (scl_rise && rx_state) begin
                    shreg <= {shreg[6:0], sda};
                end
                if (byte_done && rx_state) begin
                    bit_cnt <= '0;
                end
                case (state)
                    IDLE: ;
                    DEV: if (byte_done) begin
                        if (dev_match) begin
                            state  <= ACK_DEV;
                            sda_oe <= 1'b1;
                            o_busy <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end
                    end
                    AH: if (byte_done) begin
                        addr_hi <= shreg;
                        state   <= ACK_AH;
                        sda_oe  <= 1'b1;
                    end
                    AL: if (byte_done) begin
                        ptr    <= addr_full[P_MEM_AW-1:0];
                        state  <= ACK_AL;
                        sda_oe <= 1'b1;
                    end
                    WR: if (byte_done) begin
                        if (wr_en) begin
                            mem[ptr]   <= shreg;
                            o_wr_valid <= 1'b1;
                            o_wr_addr  <= ptr;
                            o_wr_data  <= shreg;
                        end
                        ptr    <= ptr_page_inc;
                        state  <= ACK_WR;
                        sda_oe <= 1'b1;
                    end
                    ACK_DEV: if (scl_fall) begin
                        bit_cnt <= '0;
                        if (shreg[0]) begin
                            state  <= RD;
                            tx     <= {rd_byte[6:0], 1'b0};
                            sda_oe <= ~rd_byte[7];
                        end else begin
                            state  <= AH;
                            sda_oe <= 1'b0;
                        end
                    end
                    ACK_AH: if (scl_fall) begin
                        state  <= AL;
                        sda_oe <= 1'b0;
                    end
                    ACK_AL, ACK_WR: if (scl_fall) begin
                        state  <= WR;
                        sda_oe <= 1'b0;
                    end
                    RD: if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            state   <= RD_ACK;
                            sda_oe  <= 1'b0;
                            ptr     <= ptr + P_MEM_AW'(1);
                            bit_cnt <= '0;
                        end else begin
                            sda_oe <= ~tx[7];
                            tx     <= tx << 1;
                        end
                    end
                    // bit_cnt==1 marks an ACK seen on the preceding SCL rise.
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (sda) begin
                                state <= IDLE;
                            end else begin
                                bit_cnt <= 4'd1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd1) begin
                            state   <= RD;
                            bit_cnt <= '0;
                            tx      <= {rd_byte[6:0], 1'b0};
                            sda_oe  <= ~rd_byte[7];
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iic_eeprom_slave.sv
// Directed bench for iic_eeprom_slave: behavioural I2C master, write-pulse monitor, table of single-byte writes.
module tb_iic_eeprom_slave;

    localparam int Q = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] dev_addr;
    logic       scl;
    logic       m_low;
    logic       wp = 1'b0;
    wire        sda;
    logic       busy, wr_valid;
    logic [7:0] wr_addr, wr_data;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    iic_eeprom_slave dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_dev_addr (dev_addr),
`ifdef IIC_SLAVE_WP_EN
        .i_wp       (wp),
`endif
        .i_iic_scl  (scl),
        .io_iic_sda (sda),
        .o_busy     (busy),
        .o_wr_valid (wr_valid),
        .o_wr_addr  (wr_addr),
        .o_wr_data  (wr_data)
    );

    int n_cmp = 0;
    int n_fail = 0;

    logic [15:0] wr_q[$];
    logic        watch = 1'b0;
    logic        dut_low_seen = 1'b0;
    logic        busy_seen = 1'b0;

    always @(negedge clk) begin
        if (wr_valid) wr_q.push_back({wr_addr, wr_data});
        if (!watch) begin
            dut_low_seen <= 1'b0;
            busy_seen    <= 1'b0;
        end else begin
            if (sda == 1'b0 && !m_low) dut_low_seen <= 1'b1;
            if (busy) busy_seen <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_wr(input string name, input logic [7:0] ea, input logic [7:0] ed);
        logic [15:0] e;
        check({name, "_present"}, 32'(wr_q.size() > 0), 32'd1);
        if (wr_q.size() > 0) begin
            e = wr_q.pop_front();
            check({name, "_addr"}, 32'(e[15:8]), 32'(ea));
            check({name, "_data"}, 32'(e[7:0]), 32'(ed));
        end
    endtask

    task automatic i2c_start();
        m_low = 1'b0; #Q;
        scl = 1'b1;   #Q;
        m_low = 1'b1; #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; #Q;
        scl = 1'b1;   #Q;
        m_low = 1'b0; #(4*Q);
    endtask

    task automatic send_bit(input logic b);
        m_low = ~b; #Q;
        scl = 1'b1; #(2*Q);
        scl = 1'b0; #Q;
    endtask

    task automatic recv_bit(output logic b);
        m_low = 1'b0; #Q;
        scl = 1'b1;   #Q;
        b = sda;      #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic nack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(nack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack);
    endtask

    task automatic do_write(input logic [15:0] a, input int n, input logic [7:0] d0, d1, d2,
                            output logic nack_any, output logic busy_mid);
        logic ak;
        logic [7:0] d;
        i2c_start();
        send_byte(8'hA0, ak); nack_any = ak; busy_mid = busy;
        send_byte(a[15:8], ak); nack_any |= ak;
        send_byte(a[7:0], ak);  nack_any |= ak;
        for (int k = 0; k < n; k++) begin
            d = (k == 0) ? d0 : (k == 1) ? d1 : d2;
            send_byte(d, ak); nack_any |= ak;
        end
        i2c_stop();
    endtask

    task automatic do_read(input logic rand_addr, input logic [15:0] a, input int n,
                           output logic [7:0] r0, r1, r2, output logic nack_any, output logic sda_rel);
        logic ak;
        logic [7:0] d;
        nack_any = 1'b0;
        r0 = '0; r1 = '0; r2 = '0;
        i2c_start();
        if (rand_addr) begin
            send_byte(8'hA0, ak);   nack_any |= ak;
            send_byte(a[15:8], ak); nack_any |= ak;
            send_byte(a[7:0], ak);  nack_any |= ak;
            i2c_start();
        end
        send_byte(8'hA1, ak); nack_any |= ak;
        for (int k = 0; k < n; k++) begin
            recv_byte(d, k == n - 1);
            if (k == 0) r0 = d; else if (k == 1) r1 = d; else r2 = d;
        end
        sda_rel = sda;
        i2c_stop();
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  exp_addr;
    } wvec_t;

    wvec_t vecs[6];

    initial begin
        logic nk, bm, rel, b;
        logic [7:0] r0, r1, r2;
        logic [2:0] hi3;

        vecs[0] = '{addr: 16'h0012, data: 8'h5A, exp_addr: 8'h12};
        vecs[1] = '{addr: 16'h0001, data: 8'hC1, exp_addr: 8'h01};
        vecs[2] = '{addr: 16'h0002, data: 8'hC2, exp_addr: 8'h02};
        vecs[3] = '{addr: 16'h0003, data: 8'hC3, exp_addr: 8'h03};
        vecs[4] = '{addr: 16'hFF04, data: 8'hC4, exp_addr: 8'h04};
        vecs[5] = '{addr: 16'h0080, data: 8'hE7, exp_addr: 8'h80};

        rst_n = 1'b0; dev_addr = 3'd0; scl = 1'b1; m_low = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_sda", 32'(sda), 32'd1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            do_write(vecs[i].addr, 1, vecs[i].data, 8'h00, 8'h00, nk, bm);
            check($sformatf("wr%0d_acks", i), 32'(nk), 32'd0);
            check($sformatf("wr%0d_busy_mid", i), 32'(bm), 32'd1);
            check($sformatf("wr%0d_busy_end", i), 32'(busy), 32'd0);
            check_wr($sformatf("wr%0d", i), vecs[i].exp_addr, vecs[i].data);
            check($sformatf("wr%0d_extra", i), 32'(wr_q.size()), 32'd0);
            wr_q.delete();
        end

        for (int i = 0; i < 6; i++) begin
            do_read(1'b1, vecs[i].addr, 1, r0, r1, r2, nk, rel);
            check($sformatf("rd%0d_acks", i), 32'(nk), 32'd0);
            check($sformatf("rd%0d_data", i), 32'(r0), 32'(vecs[i].data));
            check($sformatf("rd%0d_sda_rel", i), 32'(rel), 32'd1);
            check($sformatf("rd%0d_busy_end", i), 32'(busy), 32'd0);
        end
        check("rd_no_writes", 32'(wr_q.size()), 32'd0);
        wr_q.delete();

        // Page wrap: 0x1E, 0x1F, then back to 0x00 within the 32-byte page.
        do_write(16'h001E, 3, 8'h11, 8'h22, 8'h33, nk, bm);
        check("pw_acks", 32'(nk), 32'd0);
        check("pw_count", 32'(wr_q.size()), 32'd3);
        check_wr("pw0", 8'h1E, 8'h11);
        check_wr("pw1", 8'h1F, 8'h22);
        check_wr("pw2", 8'h00, 8'h33);
        wr_q.delete();

        // Current-address reads continue from pointer 0x01 left by the wrap.
        do_read(1'b0, 16'h0000, 3, r0, r1, r2, nk, rel);
        check("cur_acks", 32'(nk), 32'd0);
        check("cur_b0", 32'(r0), 32'hC1);
        check("cur_b1", 32'(r1), 32'hC2);
        check("cur_b2", 32'(r2), 32'hC3);
        do_read(1'b0, 16'h0000, 1, r0, r1, r2, nk, rel);
        check("cur_next", 32'(r0), 32'hC4);

        // Address mismatch, then a matching address with A2..A0=001.
        dev_addr = 3'b001;
        watch = 1'b1;
        i2c_start();
        send_byte(8'hA0, nk);
        check("mm_dev_nack", 32'(nk), 32'd1);
        send_byte(8'h00, nk);
        check("mm_byte_nack", 32'(nk), 32'd1);
        i2c_stop();
        check("mm_sda_driven", 32'(dut_low_seen), 32'd0);
        check("mm_busy_seen", 32'(busy_seen), 32'd0);
        check("mm_no_write", 32'(wr_q.size()), 32'd0);
        watch = 1'b0;
        i2c_start();
        send_byte(8'hA2, nk);
        check("m1_dev_ack", 32'(nk), 32'd0);
        i2c_stop();
        dev_addr = 3'b000;

        // Reset during bit 4 of a read of 0x02 (0xC2 = 1100_0010).
        do_read(1'b1, 16'h0002, 0, r0, r1, r2, nk, rel);
        i2c_start();
        send_byte(8'hA0, nk);
        send_byte(8'h00, nk);
        send_byte(8'h02, nk);
        i2c_start();
        send_byte(8'hA1, nk);
        check("mr_dev_ack", 32'(nk), 32'd0);
        for (int i = 2; i >= 0; i--) begin
            recv_bit(b);
            hi3[i] = b;
        end
        check("mr_bits765", 32'(hi3), 32'b110);
        m_low = 1'b0; #Q;
        scl = 1'b1; #20;
        check("mr_bit4_driven", 32'(sda), 32'd0);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        check("mr_sda_released", 32'(sda), 32'd1);
        check("mr_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        scl = 1'b0; #Q;
        i2c_stop();
        do_read(1'b0, 16'h0000, 1, r0, r1, r2, nk, rel);
        check("mr_after_ack", 32'(nk), 32'd0);
        check("mr_after_data", 32'(r0), 32'h33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1);
    end

endmodule
